icache: RTL and testbench



---
 rtl/icache_types_pkg.sv | 28 ++
 rtl/icache_frame_array.sv | 44 ++++
 rtl/icache.sv | 122 ++++++++++++
 tb/tb_icache.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_types_pkg.sv
// Shared types for the direct-mapped instruction cache: FSM states, frame and address layouts.
// The address layout below assumes the default of 16 frames.
package icache_types_pkg;

    localparam int SETS_DEF  = 16;
    localparam int IDX_W_DEF = $clog2(SETS_DEF);
    localparam int TAG_W_DEF = 32 - IDX_W_DEF - 2;
    // Widest tag any legal SETS can produce (SETS = 2)
    localparam int TAG_W_MAX = 29;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          data;
    } icache_frame_t;

    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [IDX_W_DEF-1:0] idx;
        logic [1:0]           bytoff;
    } icacheaddr_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage: one combinational read port, one write port, global invalidate.
// Invalidate wins over a same-cycle write's valid bit; the data and tag are still written.
module icache_frame_array #(
    parameter int SETS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        inval_i,
    input  logic [$clog2(SETS)-1:0]     rd_idx_i,
    output logic                        rd_valid_o,
    output logic [30-$clog2(SETS)-1:0]  rd_tag_o,
    output logic [31:0]                 rd_data_o,
    input  logic                        we_i,
    input  logic [$clog2(SETS)-1:0]     wr_idx_i,
    input  logic [30-$clog2(SETS)-1:0]  wr_tag_i,
    input  logic [31:0]                 wr_data_i,
    input  logic                        wr_set_valid_i
);
    localparam int TAG_W = 30 - $clog2(SETS);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    always_ff @(posedge clk_i) begin
        if (rst_i || inval_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_set_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a two-state IDLE/FETCH miss FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import icache_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t  state_q, state_d;
    logic [31:0]    miss_addr_q, miss_addr_d;
    logic           flush_pend_q, flush_pend_d;
    logic           rd_valid, lookup_hit, we, set_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]    rd_data;
    icache_frame_t  rd_frame;
    logic           unused_bytoff;

    assign unused_bytoff = ^imemaddr[1:0];

    icache_frame_array #(.SETS(SETS)) u_frames (
        .clk_i          (CLK),
        .rst_i          (RST),
        .inval_i        (flush),
        .rd_idx_i       (imemaddr[IDX_W+1:2]),
        .rd_valid_o     (rd_valid),
        .rd_tag_o       (rd_tag),
        .rd_data_o      (rd_data),
        .we_i           (we),
        .wr_idx_i       (miss_addr_q[IDX_W+1:2]),
        .wr_tag_i       (miss_addr_q[31:IDX_W+2]),
        .wr_data_i      (iload),
        .wr_set_valid_i (set_valid)
    );

    assign rd_frame   = '{valid: rd_valid, tag: TAG_W_MAX'(rd_tag), data: rd_data};
    assign lookup_hit = rd_frame.valid && (rd_frame.tag == TAG_W_MAX'(imemaddr[31:IDX_W+2]));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        ihit         = 1'b0;
        iREN         = 1'b0;
        iaddr        = '0;
        we           = 1'b0;
        set_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                ihit         = imemREN && lookup_hit;
                if (imemREN && !lookup_hit) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                // A flush seen anywhere in this FETCH keeps the filled line invalid
                if (flush) flush_pend_d = 1'b1;
                if (!iwait) begin
                    we           = 1'b1;
                    set_valid    = !(flush || flush_pend_q);
                    flush_pend_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imemload = ihit ? rd_frame.data : 32'h0;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ihit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && state_d == FETCH) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: driver pushes expected words, a monitor pops on ihit.
// The reference model is a per-set valid/tag table updated from the cache's rules.
module tb_icache;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache #(.SETS(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .flush    (flush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;
    int mem_n    = 0;
    int exp_hit  = 0;
    int exp_miss = 0;
    logic [31:0] exp_q[$];

    bit          mv[16];
    logic [25:0] mt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h2001_0045;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return mv[a[5:2]] && (mt[a[5:2]] == a[31:6]);
    endfunction

    task automatic m_fill(input logic [31:0] a);
        mv[a[5:2]] = 1'b1;
        mt[a[5:2]] = a[31:6];
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    // Memory: n busy cycles then data, for every read request
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge CLK); #1;
            if (!iREN) begin
                cnt = 0; iwait = 1'b1; iload = '0;
            end else if (cnt < mem_n) begin
                cnt++; iwait = 1'b1;
            end else begin
                iwait = 1'b0; iload = word(iaddr);
            end
        end
    end

    // Monitor: every ihit must deliver the oldest expected word
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (ihit) begin
                    if (exp_q.size() == 0) chk("unexpected_ihit", 32'd1, 32'd0);
                    else chk("imemload", imemload, exp_q.pop_front());
                end else begin
                    chk("imemload_zero_on_miss", imemload, 32'h0);
                end
            end
        end
    end

    // One fetch: optional address switch and flush at given cycle indices (0 = request cycle)
    task automatic fetch(input logic [31:0] a1, input logic [31:0] a2, input int sw_at,
                         input int n, input int flush_at);
        int lat, iren_exp, cyc, iren_n;
        logic [31:0] af, a1w, afw;
        af = a1;
        if (m_hit(a1)) begin
            lat = 0; iren_exp = 0;
        end else begin
            exp_miss++;
            if (flush_at >= 1 && flush_at <= n + 1) m_clear();
            else m_fill(a1);
            if (sw_at >= 1 && sw_at <= n + 1) af = a2;
            if (m_hit(af)) begin
                lat = n + 2; iren_exp = n + 1;
            end else begin
                exp_miss++;
                m_fill(af);
                lat = 2 * n + 4; iren_exp = 2 * n + 2;
            end
        end
        a1w = {a1[31:2], 2'b00};
        afw = {af[31:2], 2'b00};
        exp_hit++;
        exp_q.push_back(word(af));
        @(posedge CLK); #1;
        mem_n = n; imemREN = 1'b1; imemaddr = a1; flush = 1'b0;
        cyc = 0; iren_n = 0;
        forever begin
            @(negedge CLK);
            if (iREN) begin
                iren_n++;
                chk("iaddr", iaddr, (cyc <= n + 1) ? a1w : afw);
            end
            if (ihit) break;
            if (cyc >= 400) begin
                chk("fetch_timeout", 32'd0, 32'd1);
                exp_q.delete();
                break;
            end
            @(posedge CLK); #1;
            cyc++;
            flush = (cyc == flush_at);
            if (cyc == sw_at) imemaddr = a2;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("iren_cycles", 32'(iren_n), 32'(iren_exp));
    endtask

    task automatic idle_flush();
        @(posedge CLK); #1;
        imemREN = 1'b0; flush = 1'b1;
        m_clear();
        @(posedge CLK); #1;
        flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 15) == 0) a[31:6] = 26'($urandom);
        return a;
    endfunction

    initial begin
        int n, sw, fl;
        logic [31:0] a, b;
        m_clear();
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_iREN", {31'h0, iREN}, 32'h0);
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
`endif
        @(posedge CLK); #1;
        RST = 1'b0;

        // First miss: 2 busy cycles, word 0x2001_0005
        fetch(32'h40, 32'h40, -1, 2, -1);
        fetch(32'h40, 32'h40, -1, 1, -1);
        fetch(32'h43, 32'h43, -1, 1, -1);
        // Conflicting lines on the same index
        fetch(32'h80, 32'h80, -1, 1, -1);
        fetch(32'h40, 32'h40, -1, 0, -1);
`ifdef ICACHE_STATS_EN
        chk("conflict_miss_count", miss_count, 32'(exp_miss));
`endif
        // Highest index
        fetch(32'h3C, 32'h3C, -1, 0, -1);
        // Address change while filling
        fetch(32'h100, 32'h200, 2, 2, -1);
        fetch(32'h100, 32'h100, -1, 1, -1);
        // Flush during FETCH, then previously valid line
        fetch(32'h300, 32'h300, -1, 3, 2);
        fetch(32'h40, 32'h40, -1, 1, -1);
        // Flush on the completing fill cycle
        fetch(32'h344, 32'h344, -1, 2, 3);

        // Reset mid-FETCH
        @(posedge CLK); #1;
        mem_n = 5; imemREN = 1'b1; imemaddr = 32'h500;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("pre_rst_iREN", {31'h0, iREN}, 32'h1);
        @(posedge CLK); #1;
        RST = 1'b1; imemREN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_iREN", {31'h0, iREN}, 32'h0);
        chk("post_rst_ihit", {31'h0, ihit}, 32'h0);
        m_clear(); exp_q.delete(); exp_hit = 0; exp_miss = 0;
        fetch(32'h40, 32'h40, -1, 1, -1);

        for (int i = 0; i < 150; i++) begin
            n  = $urandom_range(0, 3);
            a  = rand_addr();
            b  = rand_addr();
            sw = ($urandom_range(0, 5) == 0) ? $urandom_range(1, n + 1) : -1;
            fl = ($urandom_range(0, 9) == 0) ? $urandom_range(1, n + 1) : -1;
            if ($urandom_range(0, 11) == 0) idle_flush();
            fetch(a, b, sw, n, fl);
        end

        @(posedge CLK); #1;
        imemREN = 1'b0;
        @(negedge CLK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, 32'(exp_hit));
        chk("miss_count", miss_count, 32'(exp_miss));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
